// File: rtl/delta_reconstruct.sv
// Delta-bitplane block reconstruction: transposes DATA_W+1 bitplanes into
// deltas, integrates them onto the base word and streams BLOCK_SIZE words out.
module delta_reconstruct #(
  parameter int DATA_W     = 8,
  parameter int BLOCK_SIZE = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [DATA_W-1:0]                    base_i,
  input  logic [(DATA_W+1)*(BLOCK_SIZE-1)-1:0] dbp_i,
  input  logic                                 vld_i,
  output logic                                 rdy_o,
  output logic [DATA_W-1:0]                    data_o,
  output logic                                 last_o,
  output logic                                 vld_o,
  input  logic                                 rdy_i,
  input  logic                                 clr_i
);

  localparam int NDLT  = BLOCK_SIZE - 1;
  localparam int PW    = (DATA_W + 1) * NDLT;
  localparam int IDX_W = $clog2(BLOCK_SIZE);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_acc;
  logic [PW-1:0]     r_planes;

  logic              w_last;
  logic              w_xfer;
  logic              w_accept;
  logic [DATA_W:0]   w_delta;
  logic              w_unused_sign;

  always_comb begin
    w_last   = (r_state == S_EMIT) && (r_idx == IDX_W'(BLOCK_SIZE - 1));
    w_xfer   = (r_state == S_EMIT) && rdy_i;
    rdy_o    = !clr_i && ((r_state == S_IDLE) || (w_last && rdy_i));
    w_accept = vld_i && rdy_o;
    vld_o    = (r_state == S_EMIT);
    last_o   = w_last;
    data_o   = r_acc;
  end

  // Gather bit idx of every plane; only the constant-index form stays in range
  // when idx reaches the last word (no delta is consumed there).
  always_comb begin
    w_delta = '0;
    for (int unsigned p = 0; p <= DATA_W; p++) begin
      for (int unsigned j = 0; j < NDLT; j++) begin
        if (r_idx == IDX_W'(j)) w_delta[p] = r_planes[p*NDLT + j];
      end
    end
  end

  // Truncating to DATA_W makes the sign plane irrelevant to the wrapped sum.
  assign w_unused_sign = w_delta[DATA_W];

  always_comb begin
    w_state_nxt = r_state;
    if (clr_i)                 w_state_nxt = S_IDLE;
    else if (w_accept)         w_state_nxt = S_EMIT;
    else if (w_xfer && w_last) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx    <= '0;
      r_acc    <= '0;
      r_planes <= '0;
    end else if (clr_i) begin
      r_idx    <= '0;
      r_acc    <= '0;
      r_planes <= '0;
    end else if (w_accept) begin
      r_idx    <= '0;
      r_acc    <= base_i;
      r_planes <= dbp_i;
    end else if (w_xfer && !w_last) begin
      r_idx    <= r_idx + IDX_W'(1);
      r_acc    <= r_acc + w_delta[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_delta_reconstruct.sv
// Directed bench for delta_reconstruct with immediate-assertion checks.
module tb_delta_reconstruct;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  base_i;
  logic [62:0] dbp_i;
  logic        vld_i;
  logic        rdy_o;
  logic [7:0]  data_o;
  logic        last_o;
  logic        vld_o;
  logic        rdy_i;
  logic        clr_i;

  int checks = 0;
  int errors = 0;

  logic [7:0] e1  [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
  logic [7:0] e2a [8] = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE};
  logic [7:0] e2b [8] = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
  logic [7:0] e3  [8] = '{8'h00, 8'h64, 8'hE4, 8'hE4, 8'hE4, 8'hE4, 8'hE4, 8'hE4};
  logic [62:0] dbp_p1;
  logic [62:0] dbp_m1;
  logic [62:0] dbp_mix;

  delta_reconstruct #(.DATA_W(8), .BLOCK_SIZE(8)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .base_i (base_i),
    .dbp_i  (dbp_i),
    .vld_i  (vld_i),
    .rdy_o  (rdy_o),
    .data_o (data_o),
    .last_o (last_o),
    .vld_o  (vld_o),
    .rdy_i  (rdy_i),
    .clr_i  (clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plane p bit j holds bit p of delta j.
  function automatic logic [62:0] mk_dbp(input logic [6:0][8:0] d);
    logic [62:0] r;
    r = '0;
    for (int p = 0; p < 9; p++)
      for (int j = 0; j < 7; j++)
        r[p*7 + j] = d[j][p];
    return r;
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) chk("last_implies_vld", {31'd0, (!last_o || vld_o)}, 32'd1);
  end

  task automatic load(input logic [7:0] b, input logic [62:0] d);
    vld_i = 1'b1; base_i = b; dbp_i = d;
    #1;
    chk("idle_rdy", {31'd0, rdy_o}, 32'd1);
    chk("idle_vld", {31'd0, vld_o}, 32'd0);
    @(posedge clk_i); #1;
    vld_i = 1'b0; base_i = 8'($urandom); dbp_i = {$urandom, $urandom};
  endtask

  // Transfers n words of the current block; optionally offers the next block
  // throughout so that only the last-word transfer may accept it.
  task automatic emit(input logic [7:0] exp [8], input int n, input bit rnd,
                      input bit nxt, input logic [7:0] nb, input logic [62:0] nd);
    int k = 0;
    int guard = 0;
    while (k < n) begin
      rdy_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (nxt) begin vld_i = 1'b1; base_i = nb; dbp_i = nd; end
      #1;
      chk($sformatf("vld_w%0d", k), {31'd0, vld_o}, 32'd1);
      chk($sformatf("data_w%0d", k), {24'd0, data_o}, {24'd0, exp[k]});
      chk($sformatf("last_w%0d", k), {31'd0, last_o}, {31'd0, (k == 7)});
      chk($sformatf("rdy_w%0d", k), {31'd0, rdy_o}, {31'd0, (k == 7) && rdy_i});
      if (rdy_i) k++;
      @(posedge clk_i); #1;
      if (nxt) vld_i = 1'b0;
      guard++;
      if (guard > 300) begin
        chk("emit_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic expect_idle(input string tag);
    #1;
    chk({tag, "_vld"}, {31'd0, vld_o}, 32'd0);
    chk({tag, "_last"}, {31'd0, last_o}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, rdy_o}, 32'd1);
  endtask

  initial begin
    rst_i = 1'b1; clr_i = 1'b0; vld_i = 1'b0; rdy_i = 1'b0;
    base_i = '0; dbp_i = '0;
    dbp_p1  = 63'h7F;
    dbp_m1  = '1;
    dbp_mix = mk_dbp({9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h180, 9'h064});

    repeat (2) @(posedge clk_i);
    #1; rst_i = 1'b0;
    #1;
    chk("rst_vld", {31'd0, vld_o}, 32'd0);
    chk("rst_last", {31'd0, last_o}, 32'd0);
    chk("rst_data", {24'd0, data_o}, 32'd0);
    chk("rst_rdy", {31'd0, rdy_o}, 32'd1);
    @(posedge clk_i); #1;

    // 1: deltas +1
    load(8'h10, dbp_p1);
    emit(e1, 8, 1'b0, 1'b0, 8'h00, '0);
    expect_idle("t1_end");

    // 2: deltas -1, then wrap from 0xFF
    load(8'h05, dbp_m1);
    emit(e2a, 8, 1'b0, 1'b0, 8'h00, '0);
    load(8'hFF, dbp_p1);
    emit(e2b, 8, 1'b0, 1'b0, 8'h00, '0);
    expect_idle("t2_end");

    // 3: +100 then -128 with sign plane
    load(8'h00, dbp_mix);
    emit(e3, 8, 1'b0, 1'b0, 8'h00, '0);

    // 4: back-to-back blocks with no bubble
    load(8'h10, dbp_p1);
    emit(e1, 8, 1'b0, 1'b1, 8'h05, dbp_m1);
    emit(e2a, 8, 1'b0, 1'b0, 8'h00, '0);
    expect_idle("t4_end");

    // 5: random backpressure
    load(8'h10, dbp_p1);
    emit(e1, 8, 1'b1, 1'b0, 8'h00, '0);
    rdy_i = 1'b1;
    expect_idle("t5_end");

    // 6a: soft clear after word 3
    load(8'h10, dbp_p1);
    emit(e1, 4, 1'b0, 1'b0, 8'h00, '0);
    clr_i = 1'b1; vld_i = 1'b1; base_i = 8'hAA; dbp_i = dbp_m1;
    #1;
    chk("clr_rdy", {31'd0, rdy_o}, 32'd0);
    @(posedge clk_i); #1;
    clr_i = 1'b0; vld_i = 1'b0;
    expect_idle("clr_after");
    chk("clr_data", {24'd0, data_o}, 32'd0);
    load(8'h00, dbp_mix);
    emit(e3, 8, 1'b0, 1'b0, 8'h00, '0);

    // 6b: asynchronous reset mid-block
    load(8'h10, dbp_p1);
    emit(e1, 4, 1'b0, 1'b0, 8'h00, '0);
    rst_i = 1'b1;
    #1;
    chk("arst_vld", {31'd0, vld_o}, 32'd0);
    chk("arst_data", {24'd0, data_o}, 32'd0);
    chk("arst_last", {31'd0, last_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    expect_idle("arst_after");
    load(8'h05, dbp_m1);
    emit(e2a, 8, 1'b0, 1'b0, 8'h00, '0);
    expect_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
